sv39_tlb: RTL and testbench
===========================

Name: sv39_tlb

Overview:
- Fully associative translation cache for Sv39, one instance per L1 (I or D).
- Sits directly upstream of the page-table walker: services lookups from its L1 and forwards misses to the walker's request port (l1i_req/l1i_va or l1d_req/l1d_va).
- Consumes the walker's response (phys_addr, page_fault, page_dirty, page_executable, l1*_rsp_valid) and fills an entry.
- One outstanding translation at a time.

Parameters:
- N_ENTRIES, 8, number of TLB entries; power of two, 2..32.
- IDX_W, $clog2(N_ENTRIES), width of the replacement pointer.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request from L1
- req_ready  out  1  TLB can accept a request this cycle
- req_va  in  64  virtual address
- req_st  in  1  request is a store; passed through only
- rsp_valid  out  1  one-cycle pulse, translation result
- rsp_pa  out  64  physical address = {8'd0, ppn, va[11:0]}
- rsp_hit  out  1  result came from the TLB, not a walk
- rsp_fault  out  1  walker reported page fault
- rsp_dirty  out  1  D bit of the translation
- rsp_executable  out  1  X bit of the translation
- rsp_st  out  1  echo of the latched req_st
- flush  in  1  invalidate all entries (sfence.vma)
- walk_req  out  1  one-cycle pulse to the walker
- walk_va  out  64  VA for the walk; held stable from walk_req until walk_rsp_valid
- walk_rsp_valid  in  1  walker result valid (pulse)
- walk_pa  in  64  walker physical page base (bits 11:0 are zero)
- walk_fault  in  1  walker page fault
- walk_dirty  in  1  walker D bit
- walk_executable  in  1  walker X bit

Behaviour:
- Reset (reset==0, async): state IDLE; all entry valid bits 0; replacement pointer 0; flush_pend 0. All outputs 0 except req_ready, which is 1 once reset deasserts.
- Entry contents: valid, vpn = va[38:12] (27 bits), ppn = pa[55:12] (44 bits), dirty, exec.
- States: IDLE, LOOKUP, WALK_REQ, WALK_WAIT.
- IDLE: req_ready = ~flush.
  - Handshake is req_valid & req_ready: latch va and st, go to LOOKUP.
  - If flush is asserted in IDLE, all valid bits clear at the edge and the request is not accepted; flush wins.
- LOOKUP: match = valid[i] & (vpn[i] == r_va[38:12]) over all entries, evaluated in parallel.
  - Hit: registered rsp_valid=1, rsp_hit=1, rsp_pa = {8'd0, ppn, r_va[11:0]}, dirty/exec taken from the entry; next state IDLE.
  - Miss: next state WALK_REQ.
  - Only the VPN is compared. Non-canonical VAs always miss (never filled) and are faulted by the walker.
- WALK_REQ: walk_req=1 for exactly one cycle; walk_va = r_va; next state WALK_WAIT.
- WALK_WAIT: wait indefinitely for walk_rsp_valid.
  - On walk_rsp_valid: rsp_valid=1 next cycle, rsp_hit=0, rsp_fault=walk_fault, rsp_pa = {walk_pa[63:12], r_va[11:0]}, rsp_dirty=walk_dirty, rsp_executable=walk_executable; next state IDLE.
  - If walk_fault=0 and flush_pend=0: write the entry at the replacement pointer, then pointer++ (wraps N_ENTRIES-1 -> 0).
  - Faulting walks never fill.
- Latency:
  - Hit: request accepted at edge T, rsp_valid high in cycle T+2.
  - Miss: walk_req high in cycle T+2; rsp_valid high one cycle after walk_rsp_valid.
- rsp_st echoes the latched st. rsp_valid lasts exactly one cycle. Outputs other than rsp_valid hold their values until the next response.
- Flush while not IDLE:
  - Sets flush_pend. The in-flight translation still completes and responds, but does not fill.
  - On return to IDLE, all valids clear and flush_pend clears.
  - req_ready stays 0 during the cycle flush_pend is applied.
- A flush that coincides with a hit response does not suppress that response.
- Duplicate VPNs cannot arise, since fill happens only after a miss. Two simultaneous matches are an assertion failure.
- The replacement pointer is not reset by flush.

Decomposition:
- Package sv39_pkg:
  - tlb_state_t enum (logic [1:0]).
  - Constants VPN_W=27, PPN_W=44, PG_OFF_W=12.
  - Entry struct tlb_entry_t.
- Sub-module tlb_cam:
  - Holds the entry array.
  - Computes the one-hot match vector and muxed hit data.
  - Write port (index, entry) and flush-all.
- sv39_tlb keeps the FSM, request latch, replacement pointer, flush_pend and walker interface.

Test Plan:
- Cold miss: req va=0x0000_0000_4000_1234 -> walk_req pulse with walk_va equal to that VA. Walker returns pa=0x8020_1000, fault=0, dirty=1 -> rsp_pa=0x8020_1234, rsp_hit=0, rsp_dirty=1.
- Warm hit: repeat va=0x4000_1ABC -> no walk_req; rsp_valid exactly 2 cycles after handshake; rsp_pa=0x8020_1ABC, rsp_hit=1.
- Fault: req va=0xFFFF_FFFF_0000_0000 with walker fault=1 -> rsp_fault=1. A repeat of the same VA walks again (no fill).
- Wrap: fill 9 distinct pages with N_ENTRIES=8 -> the 9th fill overwrites entry 0. The first page then misses; pages 2..9 hit.
- Flush mid-walk: assert flush during WALK_WAIT, then walker returns pa=0x9000_0000 -> response still delivered. A re-request misses; earlier cached pages also miss.
- Async reset mid-walk: drop reset in WALK_WAIT -> outputs 0 immediately. After release, req_ready=1, a late walk_rsp_valid produces no rsp_valid, and all lookups miss.

Source files
------------

// File: rtl/sv39_pkg.sv
// Shared types and constants for the Sv39 TLB: FSM state encoding, the
// entry layout, and the canonical-address test.
package sv39_pkg;

    localparam int unsigned VPN_W    = 27;
    localparam int unsigned PPN_W    = 44;
    localparam int unsigned PG_OFF_W = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WALK_REQ,
        S_WALK_WAIT
    } tlb_state_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        logic             dirty;
        logic             exec;
    } tlb_entry_t;

    // Sv39 canonical form: bits 63:39 replicate bit 38.
    function automatic logic is_canonical(input logic [63:0] va);
        return (&va[63:38]) | ~(|va[63:38]);
    endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully associative entry store: parallel VPN match, one-hot hit mux,
// a single write port and a flush that clears every valid bit.
module tlb_cam
    import sv39_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 8,
    parameter int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [VPN_W-1:0] lookup_vpn_i,
    output logic             hit_o,
    output tlb_entry_t       hit_entry_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  tlb_entry_t       wr_entry_i,
    input  logic             flush_all_i
);

    tlb_entry_t             entries_q [N_ENTRIES];
    logic [N_ENTRIES-1:0]   match;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                entries_q[wr_idx_i] <= wr_entry_i;
            end
            // Flush takes priority over a same-cycle write.
            if (flush_all_i) begin
                for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        match       = '0;
        hit_entry_o = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            match[i] = entries_q[i].valid && (entries_q[i].vpn == lookup_vpn_i);
            if (match[i]) begin
                hit_entry_o = entries_q[i];
            end
        end
    end

    assign hit_o = |match;

    // Fills only follow misses, so a VPN can never live in two entries.
    a_onehot_match: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(match));

endmodule

// File: rtl/sv39_tlb.sv
// Sv39 TLB front end: request latch, lookup/walk FSM, round-robin
// replacement and deferred flush handling around an in-flight walk.
module sv39_tlb
    import sv39_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 8,
    parameter int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_va,
    input  logic        req_st,
    output logic        rsp_valid,
    output logic [63:0] rsp_pa,
    output logic        rsp_hit,
    output logic        rsp_fault,
    output logic        rsp_dirty,
    output logic        rsp_executable,
    output logic        rsp_st,
    input  logic        flush,
    output logic        walk_req,
    output logic [63:0] walk_va,
    input  logic        walk_rsp_valid,
    input  logic [63:0] walk_pa,
    input  logic        walk_fault,
    input  logic        walk_dirty,
    input  logic        walk_executable
);

    tlb_state_t       state_q;
    logic [63:0]      va_q;
    logic             st_q;
    logic [IDX_W-1:0] ptr_q;
    logic             flush_pend_q;
    logic             rsp_valid_q, rsp_hit_q, rsp_fault_q, rsp_dirty_q, rsp_exec_q, rsp_st_q;
    logic [63:0]      rsp_pa_q;
    logic             walk_req_q;
    logic [63:0]      walk_va_q;

    logic             cam_hit;
    tlb_entry_t       hit_entry;
    tlb_entry_t       fill_entry;
    logic             lookup_hit;
    logic             fill_en;
    logic             flush_all;
    logic             req_fire;
    logic             unused_walk_off;

    assign unused_walk_off = ^walk_pa[PG_OFF_W-1:0];

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready  = reset && (state_q == S_IDLE) && !flush && !flush_pend_q;
    assign req_fire   = req_valid && req_ready;
    assign lookup_hit = cam_hit && is_canonical(va_q);
    assign fill_en    = (state_q == S_WALK_WAIT) && walk_rsp_valid && !walk_fault
                        && !flush_pend_q && is_canonical(va_q);
    assign flush_all  = (state_q == S_IDLE) && (flush || flush_pend_q);

    always_comb begin
        fill_entry       = '0;
        fill_entry.valid = 1'b1;
        fill_entry.vpn   = va_q[38:12];
        fill_entry.ppn   = walk_pa[55:12];
        fill_entry.dirty = walk_dirty;
        fill_entry.exec  = walk_executable;
    end

    tlb_cam #(
        .N_ENTRIES (N_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_cam (
        .clk_i        (clk),
        .rst_ni       (reset),
        .lookup_vpn_i (va_q[38:12]),
        .hit_o        (cam_hit),
        .hit_entry_o  (hit_entry),
        .wr_en_i      (fill_en),
        .wr_idx_i     (ptr_q),
        .wr_entry_i   (fill_entry),
        .flush_all_i  (flush_all)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            va_q         <= '0;
            st_q         <= 1'b0;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_fault_q  <= 1'b0;
            rsp_dirty_q  <= 1'b0;
            rsp_exec_q   <= 1'b0;
            rsp_st_q     <= 1'b0;
            rsp_pa_q     <= '0;
            walk_req_q   <= 1'b0;
            walk_va_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            walk_req_q  <= 1'b0;
            if (flush && (state_q != S_IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    // A pending flush is applied by the CAM this cycle.
                    flush_pend_q <= 1'b0;
                    if (req_fire) begin
                        va_q    <= req_va;
                        st_q    <= req_st;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_dirty_q <= hit_entry.dirty;
                        rsp_exec_q  <= hit_entry.exec;
                        rsp_st_q    <= st_q;
                        rsp_pa_q    <= {8'd0, hit_entry.ppn, va_q[PG_OFF_W-1:0]};
                        state_q     <= S_IDLE;
                    end else begin
                        walk_req_q <= 1'b1;
                        walk_va_q  <= va_q;
                        state_q    <= S_WALK_REQ;
                    end
                end
                S_WALK_REQ: begin
                    state_q <= S_WALK_WAIT;
                end
                S_WALK_WAIT: begin
                    if (walk_rsp_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_fault_q <= walk_fault;
                        rsp_dirty_q <= walk_dirty;
                        rsp_exec_q  <= walk_executable;
                        rsp_st_q    <= st_q;
                        rsp_pa_q    <= {walk_pa[63:12], va_q[PG_OFF_W-1:0]};
                        if (fill_en) begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_pa         = rsp_pa_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_dirty      = rsp_dirty_q;
    assign rsp_executable = rsp_exec_q;
    assign rsp_st         = rsp_st_q;
    assign walk_req       = walk_req_q;
    assign walk_va        = walk_va_q;

endmodule

// File: tb/tb_sv39_tlb.sv
// Bench for sv39_tlb: directed scenarios plus randomized traffic checked
// against a FIFO-replacement translation cache model.
module tb_sv39_tlb;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_va = '0;
    logic        req_st = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_pa;
    logic        rsp_hit, rsp_fault, rsp_dirty, rsp_executable, rsp_st;
    logic        flush = 1'b0;
    logic        walk_req;
    logic [63:0] walk_va;
    logic        walk_rsp_valid = 1'b0;
    logic [63:0] walk_pa = '0;
    logic        walk_fault = 1'b0, walk_dirty = 1'b0, walk_executable = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sv39_tlb #(.N_ENTRIES(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_st(req_st),
        .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_hit(rsp_hit), .rsp_fault(rsp_fault),
        .rsp_dirty(rsp_dirty), .rsp_executable(rsp_executable), .rsp_st(rsp_st),
        .flush(flush),
        .walk_req(walk_req), .walk_va(walk_va), .walk_rsp_valid(walk_rsp_valid),
        .walk_pa(walk_pa), .walk_fault(walk_fault), .walk_dirty(walk_dirty),
        .walk_executable(walk_executable)
    );

    // Reference model: N slots filled round-robin, looked up by page number.
    bit          m_valid [N];
    logic [63:0] m_vpn   [N];
    logic [63:0] m_ppn   [N];
    bit          m_dirty [N];
    bit          m_exec  [N];
    int          m_ptr = 0;

    function automatic bit canon(input logic [63:0] va);
        logic [63:0] top;
        top = va >> 38;
        return (top == 64'd0) || (top == 64'h3FF_FFFF);
    endfunction

    function automatic logic [63:0] page_of(input logic [63:0] va);
        return (va >> 12) & 64'h7FF_FFFF;
    endfunction

    function automatic int model_find(input logic [63:0] va);
        if (!canon(va)) return -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_vpn[i] == page_of(va)) return i;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic translate(input logic [63:0] va, input logic st, input logic [63:0] wpa,
                             input logic wf, input logic wd, input logic wx,
                             input bit flush_mid, output bit hit_seen);
        int          idx;
        int          n;
        bit          pend;
        logic [63:0] exp_pa;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        idx = model_find(va);
        req_valid = 1'b1;
        req_va    = va;
        req_st    = st;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_not_early", rsp_valid, 1'b0);
        @(posedge clk); #1;
        hit_seen = (rsp_valid === 1'b1) && (rsp_hit === 1'b1);
        check("walk_req_on_miss", walk_req, (idx < 0));
        if (idx >= 0) begin
            exp_pa = (m_ppn[idx] << 12) | (va & 64'hFFF);
            check("hit_rsp_valid", rsp_valid, 1'b1);
            check("hit_rsp_hit", rsp_hit, 1'b1);
            check("hit_rsp_pa", rsp_pa, exp_pa);
            check("hit_rsp_fault", rsp_fault, 1'b0);
            check("hit_rsp_dirty", rsp_dirty, m_dirty[idx]);
            check("hit_rsp_exec", rsp_executable, m_exec[idx]);
            check("hit_rsp_st", rsp_st, st);
        end else begin
            check("miss_no_rsp", rsp_valid, 1'b0);
            check("walk_va", walk_va, va);
            @(posedge clk); #1;
            check("walk_req_one_cycle", walk_req, 1'b0);
            check("walk_va_held", walk_va, va);
            pend = 1'b0;
            if (flush_mid) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                pend  = 1'b1;
                check("no_rsp_during_flush", rsp_valid, 1'b0);
            end
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk); #1;
                check("no_rsp_while_waiting", rsp_valid, 1'b0);
            end
            walk_rsp_valid  = 1'b1;
            walk_pa         = wpa;
            walk_fault      = wf;
            walk_dirty      = wd;
            walk_executable = wx;
            @(posedge clk); #1;
            walk_rsp_valid = 1'b0;
            exp_pa = (wpa & ~64'hFFF) | (va & 64'hFFF);
            check("walk_rsp_valid", rsp_valid, 1'b1);
            check("walk_rsp_hit", rsp_hit, 1'b0);
            check("walk_rsp_pa", rsp_pa, exp_pa);
            check("walk_rsp_fault", rsp_fault, wf);
            check("walk_rsp_dirty", rsp_dirty, wd);
            check("walk_rsp_exec", rsp_executable, wx);
            check("walk_rsp_st", rsp_st, st);
            if (pend) begin
                check("ready_low_flush_apply", req_ready, 1'b0);
                model_clear();
            end else if (!wf && canon(va)) begin
                m_valid[m_ptr] = 1'b1;
                m_vpn[m_ptr]   = page_of(va);
                m_ppn[m_ptr]   = (wpa >> 12) & 64'hFFF_FFFF_FFFF;
                m_dirty[m_ptr] = wd;
                m_exec[m_ptr]  = wx;
                m_ptr          = (m_ptr + 1) % N;
            end
        end
        @(posedge clk); #1;
        check("rsp_single_pulse", rsp_valid, 1'b0);
        check("rsp_pa_hold", rsp_pa, exp_pa);
    endtask

    task automatic idle_flush(input logic [63:0] va);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_va    = va;
        #1;
        check("ready_low_on_flush", req_ready, 1'b0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        check("flush_blocks_request", walk_req | rsp_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          h;
        logic [63:0] vpool [12];
        logic [63:0] va, v;
        int          k;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_walk_req", walk_req, 1'b0);
        check("reset_walk_va", walk_va, 64'd0);
        check("reset_rsp_pa", rsp_pa, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_ready", req_ready, 1'b1);

        // Cold miss then warm hit on the same page.
        translate(64'h0000_0000_4000_1234, 1'b0, 64'h0000_0000_8020_1000, 1'b0, 1'b1, 1'b0, 1'b0, h);
        check("cold_pa", rsp_pa, 64'h0000_0000_8020_1234);
        check("cold_hit", h, 1'b0);
        translate(64'h0000_0000_4000_1ABC, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, h);
        check("warm_pa", rsp_pa, 64'h0000_0000_8020_1ABC);
        check("warm_hit", h, 1'b1);

        // Faulting walk leaves nothing behind.
        translate(64'hFFFF_FFFF_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, h);
        check("fault_flag", rsp_fault, 1'b1);
        translate(64'hFFFF_FFFF_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, h);
        check("fault_rewalks", h, 1'b0);

        // Eight more fills: the ninth overall evicts the first page.
        for (int i = 0; i < 8; i++) begin
            translate(64'h5000_0000 + 64'(i) * 64'h1000 + 64'h10, 1'b0,
                      64'h0012_3400_0000_0000 + 64'(i) * 64'h1000, 1'b0, i[0], i[1], 1'b0, h);
        end
        for (int i = 0; i < 8; i++) begin
            translate(64'h5000_0000 + 64'(i) * 64'h1000 + 64'h20, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, h);
            check("wrap_survivor_hit", h, 1'b1);
        end
        translate(64'h0000_0000_4000_1000, 1'b0, 64'h0000_0000_8020_1000, 1'b0, 1'b1, 1'b0, 1'b0, h);
        check("wrap_evicted_miss", h, 1'b0);

        // Flush during a walk: response still arrives, cache ends empty.
        translate(64'h0000_0000_6000_0123, 1'b0, 64'h0000_0000_9000_0000, 1'b0, 1'b0, 1'b1, 1'b1, h);
        check("flush_mid_pa", rsp_pa, 64'h0000_0000_9000_0123);
        translate(64'h0000_0000_6000_0123, 1'b0, 64'h0000_0000_9000_0000, 1'b0, 1'b0, 1'b1, 1'b0, h);
        check("flush_rerequest_miss", h, 1'b0);
        translate(64'h0000_0000_5000_3000, 1'b0, 64'h0000_0000_A000_0000, 1'b0, 1'b0, 1'b0, 1'b0, h);
        check("flush_old_page_miss", h, 1'b0);

        // Flush in IDLE beats a coincident request.
        idle_flush(64'h0000_0000_5000_3000);
        translate(64'h0000_0000_5000_3000, 1'b0, 64'h0000_0000_A000_0000, 1'b0, 1'b0, 1'b0, 1'b0, h);
        check("idle_flush_miss", h, 1'b0);

        // Randomized traffic over a small page pool.
        for (int i = 0; i < 12; i++) begin
            v = 64'($urandom & 32'h07FF_FFFF);
            if (v[26]) v = v | 64'hFFFF_FFFF_F800_0000;
            vpool[i] = v << 12;
        end
        for (int t = 0; t < 150; t++) begin
            k  = $urandom_range(0, 11);
            va = vpool[k] | 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) == 0) va = va ^ (64'd1 << 50);
            if ($urandom_range(0, 24) == 0) idle_flush(va);
            translate(va, 1'($urandom_range(0, 1)), {$urandom, $urandom} & ~64'hFFF,
                      (!canon(va)) || ($urandom_range(0, 9) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0), h);
        end

        // Fill one page so the post-reset lookup has something to lose.
        translate(64'h0000_0000_7000_0456, 1'b0, 64'h0000_0000_B000_0000, 1'b0, 1'b1, 1'b1, 1'b0, h);

        // Asynchronous reset while a walk is outstanding.
        @(negedge clk);
        req_valid = 1'b1;
        req_va    = 64'h0000_0000_7100_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_walk_started", walk_req, 1'b1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_async_walk_va", walk_va, 64'd0);
        check("rst_async_rsp_pa", rsp_pa, 64'd0);
        check("rst_async_ready", req_ready, 1'b0);
        check("rst_async_dirty", rsp_dirty, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        m_ptr = 0;
        #1;
        check("rst_release_ready", req_ready, 1'b1);
        @(negedge clk);
        walk_rsp_valid = 1'b1;
        walk_pa        = 64'h0000_0000_C000_0000;
        @(negedge clk);
        walk_rsp_valid = 1'b0;
        check("late_walk_ignored", rsp_valid, 1'b0);
        @(negedge clk);
        check("late_walk_ignored2", rsp_valid, 1'b0);
        translate(64'h0000_0000_7000_0456, 1'b0, 64'h0000_0000_B000_0000, 1'b0, 1'b0, 1'b0, 1'b0, h);
        check("rst_cleared_miss", h, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
